hongwai_rx: RTL and testbench
=============================

# hongwai_rx

Infrared receiver/decoder for the air-conditioner remote link. It takes the demodulated, active-low output of a 38 kHz IR receiver module and measures mark and space durations at 125 MHz. It decodes the two-segment frame (35 bits, connect code, 32 bits) and presents the words on `data35`/`data32` with a one-cycle valid strobe. These are the words the IR transmitter consumes as its incoming command.

## Interface
- `LEAD_MARK_MIN`, 937500: lead mark lower bound (7.5 ms).
- `LEAD_MARK_MAX`, 1312500: lead mark upper bound (10.5 ms).
- `LEAD_SPACE_MIN`, 437500: lead space lower bound (3.5 ms).
- `LEAD_SPACE_MAX`, 687500: lead space upper bound (5.5 ms).
- `BIT_MARK_MIN`, 50000: bit, connect or end mark lower bound (400 us).
- `BIT_MARK_MAX`, 137500: bit, connect or end mark upper bound (1.1 ms).
- `ZERO_SPACE_MIN`, 25000: shortest legal bit space (200 us).
- `ONE_THR`, 112500: space at or above this length decodes as 1 (900 us).
- `ONE_SPACE_MAX`, 275000: longest legal bit space (2.2 ms).
- `CONN_SPACE_MIN`, 1875000: connect space lower bound (15 ms).
- `CONN_SPACE_MAX`, 3125000: connect space upper bound (25 ms).
- `clk` in 1: 125 MHz system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `ir_in` in 1: demodulated IR line, asynchronous. Low = carrier (mark), high = space or idle.
- `data35` out 35: last valid first segment. First received bit is at [34].
- `data32` out 32: last valid second segment. First received bit is at [31].
- `frame_valid` out 1: one-cycle pulse when `data35`/`data32` update.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Input conditioning**
  - `ir_in` passes through a two-flop synchronizer; both flops reset to 1.
  - Rise and fall detection compares the synchronized line against a one-cycle delayed copy, combinationally.
- **Duration counter**
  - `dur` is 22 bits, cleared on every synchronized edge.
  - It increments every other cycle and saturates at 2^22-1.
  - On an edge, the pre-clear value of `dur` is the measured duration of the level that just ended.
  - A duration is "in window" when MIN <= `dur` <= MAX.
- **FSM states and transitions**
  - IDLE: a fall goes to LEAD_M.
  - LEAD_M: a rise with `dur` in the lead-mark window goes to LEAD_S.
  - LEAD_S: a fall with `dur` in the lead-space window goes to D35_M.
  - D35_M: a rise with `dur` in the bit-mark window goes to D35_S.
  - D35_S: a fall with `dur` in [ZERO_SPACE_MIN, ONE_SPACE_MAX] shifts in a bit: 1 if `dur` >= ONE_THR, else 0. After the 35th bit, go to CONN_M; otherwise go to D35_M. The fall that closes bit 35 starts the connect mark.
  - CONN_M: a rise with `dur` in the bit-mark window goes to CONN_S.
  - CONN_S: a fall with `dur` in the connect window goes to D32_M.
  - D32_M and D32_S: same rules as D35_M and D35_S, with a 32-bit count. The fall that closes bit 32 is the start of the frame's end mark.
- **Frame completion**
  - On the fall that closes bit 32, load `data35`/`data32` from the internal shift registers, pulse `frame_valid`, and return to IDLE.
  - The rise that ends the end mark is ignored, because IDLE reacts only to falls.
- **Error handling**
  - An edge with `dur` out of window, in any non-IDLE state, pulses `frame_err` and returns to IDLE.
  - If `dur` exceeds the current phase's MAX with no edge (timeout), the same error action is taken.
  - A frame whose line stays high after the last bit mark therefore times out as an error.
  - On error, the output registers are not touched.
- **Output rules**
  - The shift registers are internal; the outputs change only on `frame_valid`.
  - `frame_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data35`=0, `data32`=0, `frame_valid`=0, `frame_err`=0, `busy`=0.
- Reset is asynchronous mid-frame: outputs clear immediately and the FSM goes to IDLE.
- If reset is released while the line is low, the next fall is treated as a lead mark. Mid-frame this fails the window and gives `frame_err`.
- Latency: `frame_valid` is high on the 3rd `clk` edge after the first synchronizer flop captures the closing fall (2 synchronizer stages plus 1 FSM register).
- `frame_err` has the same 3-cycle latency for edge-triggered errors. For a timeout, it asserts 1 cycle after `dur` passes MAX.
- `busy` rises 3 cycles after the first fall and falls in the same cycle as the `frame_valid`/`frame_err` pulse.
- Pulse widths below 2 clk cycles are not guaranteed to be seen.

## Test plan
- **Reset:** hold `rst`=0 with `ir_in`=1, then release. All outputs are 0, and they stay 0 for 20 ms of idle line.
- **Nominal frame:** 9 ms / 4.5 ms lead, bits of 750 us mark plus 450 us space (0) or 1500 us space (1), connect 750 us / 20 ms, end mark 750 us. Use `data35`=35'h5_5555_5555, `data32`=32'hA5C3_0F81. Exactly one `frame_valid`, both outputs match, `frame_err` never high.
- **Bad lead:** 6 ms lead mark. `frame_err` pulses 3 cycles after the rise, there is no `frame_valid`, and the outputs keep their prior frame values.
- **Bad connect:** connect space of 12 ms. `frame_err` pulses; a nominal frame sent afterwards decodes correctly.
- **Missing end mark:** the line stays high after the bit 32 mark. `frame_err` pulses when the space exceeds 2.2 ms, and the outputs are unchanged.
- **Reset mid-frame:** assert `rst` during bit 20 of `data35`. Outputs are 0 immediately. After release, a full nominal frame gives `frame_valid` with the correct data.

Source files
------------

// File: rtl/hongwai_rx.sv
// -----------------------------------------------------------------------------
// hongwai_rx
// Infrared receiver/decoder for the air-conditioner remote link.
// The demodulated, active-low IR line is synchronized, and the length of every
// mark and space is measured. A two-segment frame is decoded: lead, 35 data
// bits, connect code, 32 data bits, end mark.
//
// All duration parameters are expressed in clk cycles (125 MHz by default).
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   ir_in        demodulated IR line (low = mark, high = space/idle), async
//   data35       last valid first segment, first received bit at [34]
//   data32       last valid second segment, first received bit at [31]
//   frame_valid  one-cycle pulse when data35/data32 update
//   frame_err    one-cycle pulse when a frame is aborted
//   busy         high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module hongwai_rx #(
    parameter int unsigned LEAD_MARK_MIN  = 937500,
    parameter int unsigned LEAD_MARK_MAX  = 1312500,
    parameter int unsigned LEAD_SPACE_MIN = 437500,
    parameter int unsigned LEAD_SPACE_MAX = 687500,
    parameter int unsigned BIT_MARK_MIN   = 50000,
    parameter int unsigned BIT_MARK_MAX   = 137500,
    parameter int unsigned ZERO_SPACE_MIN = 25000,
    parameter int unsigned ONE_THR        = 112500,
    parameter int unsigned ONE_SPACE_MAX  = 275000,
    parameter int unsigned CONN_SPACE_MIN = 1875000,
    parameter int unsigned CONN_SPACE_MAX = 3125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_in,
    output logic [34:0] data35,
    output logic [31:0] data32,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, LEAD_M, LEAD_S, D35_M, D35_S, CONN_M, CONN_S, D32_M, D32_S
    } state_t;

    // The duration counter ticks once every two cycles, so its value doubled
    // is the elapsed time in clk cycles; all windows are compared in cycles.
    localparam logic [22:0] LM_LO = 23'(LEAD_MARK_MIN);
    localparam logic [22:0] LM_HI = 23'(LEAD_MARK_MAX);
    localparam logic [22:0] LS_LO = 23'(LEAD_SPACE_MIN);
    localparam logic [22:0] LS_HI = 23'(LEAD_SPACE_MAX);
    localparam logic [22:0] BM_LO = 23'(BIT_MARK_MIN);
    localparam logic [22:0] BM_HI = 23'(BIT_MARK_MAX);
    localparam logic [22:0] BS_LO = 23'(ZERO_SPACE_MIN);
    localparam logic [22:0] ONE_T = 23'(ONE_THR);
    localparam logic [22:0] BS_HI = 23'(ONE_SPACE_MAX);
    localparam logic [22:0] CS_LO = 23'(CONN_SPACE_MIN);
    localparam logic [22:0] CS_HI = 23'(CONN_SPACE_MAX);

    function automatic logic in_win(input logic [22:0] v,
                                    input logic [22:0] lo,
                                    input logic [22:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic        sync1_q, sync2_q, dly_q;
    logic [21:0] dur_q, dur_d;
    logic        half_q, half_d;
    logic        rise, fall, lvl_edge;
    logic [22:0] cyc;
    logic        bit_val;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [34:0] sh35_q, sh35_d;
    logic [31:0] sh32_q, sh32_d;
    logic [34:0] data35_q, data35_d;
    logic [31:0] data32_q, data32_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [22:0] win_lo, win_hi;
    logic        abort;

    // Synchronizer idles high so a quiet line after reset shows no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
            dur_q   <= '0;
            half_q  <= 1'b0;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            dur_q   <= dur_d;
            half_q  <= half_d;
        end
    end

    assign rise     = sync2_q & ~dly_q;
    assign fall     = ~sync2_q & dly_q;
    assign lvl_edge = rise | fall;
    assign cyc      = {dur_q, 1'b0};
    assign bit_val  = (cyc >= ONE_T);

    // On an edge dur_q still holds the length of the level that just ended.
    always_comb begin
        dur_d  = dur_q;
        half_d = ~half_q;
        if (lvl_edge) begin
            dur_d  = '0;
            half_d = 1'b0;
        end else if (half_q && (dur_q != '1)) begin
            dur_d = dur_q + 22'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh35_q   <= '0;
            sh32_q   <= '0;
            data35_q <= '0;
            data32_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh35_q   <= sh35_d;
            sh32_q   <= sh32_d;
            data35_q <= data35_d;
            data32_q <= data32_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Acceptance window of the level currently being timed.
    always_comb begin
        win_lo = BM_LO;
        win_hi = BM_HI;
        unique case (state_q)
            LEAD_M:          begin win_lo = LM_LO; win_hi = LM_HI; end
            LEAD_S:          begin win_lo = LS_LO; win_hi = LS_HI; end
            D35_S, D32_S:    begin win_lo = BS_LO; win_hi = BS_HI; end
            CONN_S:          begin win_lo = CS_LO; win_hi = CS_HI; end
            default:         begin win_lo = BM_LO; win_hi = BM_HI; end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh35_d   = sh35_q;
        sh32_d   = sh32_q;
        data35_d = data35_q;
        data32_d = data32_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        abort    = 1'b0;

        if (state_q == IDLE) begin
            // The rise ending an end mark lands here and is ignored.
            if (fall) state_d = LEAD_M;
        end else if (lvl_edge) begin
            if (!in_win(cyc, win_lo, win_hi)) begin
                abort = 1'b1;
            end else begin
                unique case (state_q)
                    LEAD_M: state_d = LEAD_S;
                    LEAD_S: begin
                        state_d = D35_M;
                        cnt_d   = '0;
                    end
                    D35_M:  state_d = D35_S;
                    D35_S: begin
                        sh35_d = {sh35_q[33:0], bit_val};
                        if (cnt_q == 6'd34) begin
                            cnt_d   = '0;
                            state_d = CONN_M;
                        end else begin
                            cnt_d   = cnt_q + 6'd1;
                            state_d = D35_M;
                        end
                    end
                    CONN_M: state_d = CONN_S;
                    CONN_S: begin
                        state_d = D32_M;
                        cnt_d   = '0;
                    end
                    D32_M:  state_d = D32_S;
                    D32_S: begin
                        sh32_d = {sh32_q[30:0], bit_val};
                        if (cnt_q == 6'd31) begin
                            cnt_d    = '0;
                            data35_d = sh35_q;
                            data32_d = {sh32_q[30:0], bit_val};
                            valid_d  = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            cnt_d   = cnt_q + 6'd1;
                            state_d = D32_M;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (cyc > win_hi) begin
            // Level has outlasted its window without an edge.
            abort = 1'b1;
        end

        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        data35      = data35_q;
        data32      = data32_q;
        frame_valid = valid_q;
        frame_err   = err_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_hongwai_rx.sv
// -----------------------------------------------------------------------------
// tb_hongwai_rx
// Directed bench for hongwai_rx with all timing parameters scaled down by 2500
// so full frames stay short. Scaled nominal timings in clk cycles:
// lead 450/225, bit mark 38, zero space 22, one space 75, connect 38/1000.
// -----------------------------------------------------------------------------
module tb_hongwai_rx;

    localparam int T_LM    = 450;
    localparam int T_LS    = 225;
    localparam int T_BM    = 38;
    localparam int T_S0    = 22;
    localparam int T_S1    = 75;
    localparam int T_CS    = 1000;
    localparam int T_BADLM = 300;
    localparam int T_BADCS = 600;

    localparam logic [34:0] D35A = 35'h5_5555_5555;
    localparam logic [31:0] D32A = 32'hA5C3_0F81;
    localparam logic [34:0] D35B = 35'h4_8D15_9E27;
    localparam logic [31:0] D32B = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        ir_in;
    logic [34:0] data35;
    logic [31:0] data32;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;
    int nvalid = 0;
    int nerr = 0;
    bit both = 1'b0;
    int v0, e0;

    hongwai_rx #(
        .LEAD_MARK_MIN (375),
        .LEAD_MARK_MAX (525),
        .LEAD_SPACE_MIN(175),
        .LEAD_SPACE_MAX(275),
        .BIT_MARK_MIN  (20),
        .BIT_MARK_MAX  (55),
        .ZERO_SPACE_MIN(10),
        .ONE_THR       (45),
        .ONE_SPACE_MAX (110),
        .CONN_SPACE_MIN(750),
        .CONN_SPACE_MAX(1250)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (ir_in),
        .data35     (data35),
        .data32     (data32),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nvalid <= nvalid + 1;
        if (frame_err)   nerr   <= nerr + 1;
        if (frame_valid && frame_err) both <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int cycles);
        ir_in = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bits(input logic [34:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b0, T_BM);
            drive(1'b1, v[i] ? T_S1 : T_S0);
        end
    endtask

    // Lead plus the 35-bit segment; line is high when this returns.
    task automatic send_head(input logic [34:0] d35);
        drive(1'b0, T_LM);
        drive(1'b1, T_LS);
        send_bits(d35, 35);
    endtask

    task automatic send_frame(input logic [34:0] d35, input logic [31:0] d32);
        send_head(d35);
        drive(1'b0, T_BM);
        drive(1'b1, T_CS);
        send_bits({3'b000, d32}, 32);
        drive(1'b0, T_BM);
        drive(1'b1, 60);
    endtask

    initial begin
        // Reset with idle line
        rst   = 1'b0;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data35", 64'(data35), 64'd0);
        check("rst_data32", 64'(data32), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_data35", 64'(data35), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_nvalid", 64'(nvalid), 64'd0);
        check("idle_nerr", 64'(nerr), 64'd0);

        // Nominal frame with latency checks on busy and frame_valid
        ir_in = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_rise", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'd1);
        repeat (T_LM - 3) @(negedge clk);
        drive(1'b1, T_LS);
        send_bits(D35A, 35);
        check("busy_mid_frame", 64'(busy), 64'd1);
        drive(1'b0, T_BM);
        drive(1'b1, T_CS);
        send_bits({3'b000, D32A}, 32);
        ir_in = 1'b0;
        repeat (2) @(negedge clk);
        check("valid_early", 64'(frame_valid), 64'd0);
        check("data35_before_valid", 64'(data35), 64'd0);
        @(negedge clk);
        check("valid_pulse", 64'(frame_valid), 64'd1);
        check("nom_data35", 64'(data35), 64'(D35A));
        check("nom_data32", 64'(data32), 64'(D32A));
        check("busy_fall", 64'(busy), 64'd0);
        @(negedge clk);
        check("valid_one_cycle", 64'(frame_valid), 64'd0);
        repeat (T_BM - 4) @(negedge clk);
        drive(1'b1, 60);
        check("nom_nvalid", 64'(nvalid), 64'd1);
        check("nom_nerr", 64'(nerr), 64'd0);

        // Bad lead: 6 ms mark
        drive(1'b0, T_BADLM);
        ir_in = 1'b1;
        repeat (2) @(negedge clk);
        check("badlead_err_early", 64'(frame_err), 64'd0);
        @(negedge clk);
        check("badlead_err_pulse", 64'(frame_err), 64'd1);
        check("badlead_valid", 64'(frame_valid), 64'd0);
        check("badlead_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("badlead_err_one_cycle", 64'(frame_err), 64'd0);
        repeat (100) @(negedge clk);
        check("badlead_data35", 64'(data35), 64'(D35A));
        check("badlead_data32", 64'(data32), 64'(D32A));
        check("badlead_nerr", 64'(nerr), 64'd1);
        check("badlead_nvalid", 64'(nvalid), 64'd1);

        // Bad connect: 12 ms connect space, then a nominal frame
        e0 = nerr;
        v0 = nvalid;
        send_head(D35B);
        drive(1'b0, T_BM);
        drive(1'b1, T_BADCS);
        drive(1'b0, T_BM);
        drive(1'b1, 100);
        check("badconn_nerr", 64'(nerr - e0), 64'd1);
        check("badconn_nvalid", 64'(nvalid - v0), 64'd0);
        check("badconn_data35", 64'(data35), 64'(D35A));
        send_frame(D35B, D32B);
        check("after_badconn_nvalid", 64'(nvalid - v0), 64'd1);
        check("after_badconn_nerr", 64'(nerr - e0), 64'd1);
        check("after_badconn_data35", 64'(data35), 64'(D35B));
        check("after_badconn_data32", 64'(data32), 64'(D32B));

        // Missing end mark: line stays high after the bit-32 mark
        e0 = nerr;
        v0 = nvalid;
        send_head(D35A);
        drive(1'b0, T_BM);
        drive(1'b1, T_CS);
        send_bits({3'b000, D32A} >> 1, 31);
        drive(1'b0, T_BM);
        drive(1'b1, 300);
        check("noend_nerr", 64'(nerr - e0), 64'd1);
        check("noend_nvalid", 64'(nvalid - v0), 64'd0);
        check("noend_data35", 64'(data35), 64'(D35B));
        check("noend_data32", 64'(data32), 64'(D32B));
        check("noend_busy", 64'(busy), 64'd0);

        // Reset during bit 20 of the first segment
        drive(1'b0, T_LM);
        drive(1'b1, T_LS);
        send_bits(D35A >> 16, 19);
        drive(1'b0, 10);
        #1 rst = 1'b0;
        #1;
        check("midrst_data35", 64'(data35), 64'd0);
        check("midrst_data32", 64'(data32), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        v0 = nvalid;
        e0 = nerr;
        send_frame(D35A, D32A);
        check("postrst_nvalid", 64'(nvalid - v0), 64'd1);
        check("postrst_nerr", 64'(nerr - e0), 64'd0);
        check("postrst_data35", 64'(data35), 64'(D35A));
        check("postrst_data32", 64'(data32), 64'(D32A));

        check("valid_err_overlap", 64'(both), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
